// File: rtl/lvds_video_tx.sv
// Pixel-to-LVDS serializer: buffers pixels in a small FIFO and shifts 7-bit lane words out at the bit clock.
// Optional underflow statistics counter enabled by defining LVDS_TX_STATS_EN.
module lvds_video_tx #(
    parameter int LANES      = 4,
    parameter int MAP_MODE   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_en,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [7:0]                    pix_red,
    input  logic [7:0]                    pix_green,
    input  logic [7:0]                    pix_blue,
    input  logic                          pix_hsync,
    input  logic                          pix_vsync,
    input  logic                          pix_de,
    output logic [LANES-1:0]              lane_out,
    output logic                          clk_lane_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic [15:0]                   underflow_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [6:0] CLK_PAT = 7'b1100011;

    if (LANES != 3 && LANES != 4) begin : g_bad_lanes
        $error("lvds_video_tx: LANES must be 3 or 4");
    end
    if (MAP_MODE < 0 || MAP_MODE > 2) begin : g_bad_map
        $error("lvds_video_tx: MAP_MODE must be 0, 1 or 2");
    end
    if (LANES == 3 && MAP_MODE != 0) begin : g_bad_combo
        $error("lvds_video_tx: 24-bit mappings need LANES=4");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lvds_video_tx: FIFO_DEPTH must be a power of two from 2 to 16");
    end

    // Packs one pixel into four 7-bit lane words {L3,L2,L1,L0}; bit 6 of each goes out first.
    function automatic logic [27:0] map_lanes(input logic [26:0] px);
        logic [7:0] r, g, b;
        logic       hs, vs, de;
        logic [6:0] l0, l1, l2, l3;
        {r, g, b, hs, vs, de} = px;
        if (MAP_MODE == 1) begin
            l0 = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
            l1 = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
            l2 = {b[2], b[3], b[4], b[5], hs, vs, de};
            l3 = {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
        end else begin
            l0 = {r[2], r[3], r[4], r[5], r[6], r[7], g[2]};
            l1 = {g[3], g[4], g[5], g[6], g[7], b[2], b[3]};
            l2 = {b[4], b[5], b[6], b[7], hs, vs, de};
            l3 = (MAP_MODE == 2) ? {r[0], r[1], g[0], g[1], b[0], b[1], 1'b0} : 7'd0;
        end
        return {l3, l2, l1, l0};
    endfunction

    // Stage p0: pixel FIFO
    logic [26:0]   fifo_mem_p0 [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_p0, rd_ptr_p0;
    logic [LW-1:0] level_p0;
    logic          ready_en;
    logic          push, pop, load, blank_load;

    // Stage p1: slot counter and lane shift words
    logic [2:0]    slot_p1;
    logic          run_p1;
    logic [6:0]    word_p1 [4];
    logic          last_hs_p1, last_vs_p1;
    logic [26:0]   pix_sel;
    logic [27:0]   mapped;
    logic [3:0]    lane_msb;

    assign pix_ready  = ready_en && (level_p0 != LW'(FIFO_DEPTH));
    assign fifo_level = level_p0;
    assign push       = pix_valid && pix_ready;
    assign load       = tx_en && (!run_p1 || slot_p1 == 3'd6);
    assign pop        = load && (level_p0 != '0);
    assign blank_load = load && (level_p0 == '0);
    assign pix_sel    = pop ? fifo_mem_p0[rd_ptr_p0] : {24'd0, last_hs_p1, last_vs_p1, 1'b0};
    assign mapped     = map_lanes(pix_sel);
    assign lane_msb   = {word_p1[3][6], word_p1[2][6], word_p1[1][6], word_p1[0][6]};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_p0[wr_ptr_p0] <= {pix_red, pix_green, pix_blue, pix_hsync, pix_vsync, pix_de};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            level_p0  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
            if (pop)  rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
            case ({push, pop})
                2'b10:   level_p0 <= level_p0 + LW'(1);
                2'b01:   level_p0 <= level_p0 - LW'(1);
                default: level_p0 <= level_p0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_p1      <= 3'd0;
            run_p1       <= 1'b0;
            last_hs_p1   <= 1'b0;
            last_vs_p1   <= 1'b0;
            underflow    <= 1'b0;
            lane_out     <= '0;
            clk_lane_out <= 1'b0;
            for (int i = 0; i < 4; i++) word_p1[i] <= 7'd0;
        end else begin
            run_p1 <= tx_en;
            if (!tx_en) begin
                slot_p1      <= 3'd0;
                lane_out     <= '0;
                clk_lane_out <= 1'b0;
            end else begin
                // Stage p2: serial outputs lag the selected slot by one edge
                if (run_p1) begin
                    lane_out     <= lane_msb[LANES-1:0];
                    clk_lane_out <= CLK_PAT[3'd6 - slot_p1];
                end else begin
                    lane_out     <= '0;
                    clk_lane_out <= 1'b0;
                end
                if (load) begin
                    slot_p1    <= 3'd0;
                    last_hs_p1 <= pix_sel[2];
                    last_vs_p1 <= pix_sel[1];
                    for (int i = 0; i < 4; i++) word_p1[i] <= mapped[i*7 +: 7];
                    if (blank_load) underflow <= 1'b1;
                end else begin
                    slot_p1 <= slot_p1 + 3'd1;
                    for (int i = 0; i < 4; i++) word_p1[i] <= {word_p1[i][5:0], 1'b0};
                end
            end
        end
    end

`ifdef LVDS_TX_STATS_EN
    logic [15:0] ucnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_p1 <= 16'd0;
        end else if (blank_load && ucnt_p1 != 16'hFFFF) begin
            ucnt_p1 <= ucnt_p1 + 16'd1;
        end
    end

    assign underflow_count = ucnt_p1;
`else
    assign underflow_count = 16'd0;
`endif

endmodule

// File: tb/tb_lvds_video_tx.sv
// Directed, table-driven bench for lvds_video_tx: VESA and JEIDA instances share one stimulus stream.
module tb_lvds_video_tx;

    logic        clk = 1'b0;
    logic        rst_n, tx_en, pix_valid;
    logic [7:0]  pix_red, pix_green, pix_blue;
    logic        pix_hsync, pix_vsync, pix_de;
    logic        pix_ready, pix_ready_m2;
    logic [3:0]  lane_out, lane_out_m2;
    logic        clk_lane_out, clk_lane_m2;
    logic [2:0]  fifo_level, fifo_level_m2;
    logic        underflow, underflow_m2;
    logic [15:0] underflow_count, underflow_count_m2;

`ifdef LVDS_TX_STATS_EN
    localparam logic [15:0] EXP_UCNT3 = 16'd3;
`else
    localparam logic [15:0] EXP_UCNT3 = 16'd0;
`endif

    lvds_video_tx #(.LANES(4), .MAP_MODE(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
        .pix_hsync(pix_hsync), .pix_vsync(pix_vsync), .pix_de(pix_de),
        .lane_out(lane_out), .clk_lane_out(clk_lane_out), .fifo_level(fifo_level),
        .underflow(underflow), .underflow_count(underflow_count)
    );

    lvds_video_tx #(.LANES(4), .MAP_MODE(2), .FIFO_DEPTH(4)) dut_m2 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .pix_valid(pix_valid), .pix_ready(pix_ready_m2),
        .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
        .pix_hsync(pix_hsync), .pix_vsync(pix_vsync), .pix_de(pix_de),
        .lane_out(lane_out_m2), .clk_lane_out(clk_lane_m2), .fifo_level(fifo_level_m2),
        .underflow(underflow_m2), .underflow_count(underflow_count_m2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r, g, b;
        logic        hs, vs, de;
        logic [27:0] exp1;   // {L3,L2,L1,L0} for MAP_MODE=1
        logic [27:0] exp2;   // {L3,L2,L1,L0} for MAP_MODE=2
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input vec_t v);
        pix_red = v.r; pix_green = v.g; pix_blue = v.b;
        pix_hsync = v.hs; pix_vsync = v.vs; pix_de = v.de;
    endtask

    task automatic push(input vec_t v);
        set_pix(v);
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
    endtask

    // Samples seven slots and reassembles each lane word, bit 6 first.
    task automatic collect7(output logic [27:0] w1, output logic [27:0] w2, output logic [6:0] ck);
        w1 = '0; w2 = '0; ck = '0;
        for (int k = 0; k < 7; k++) begin
            step();
            for (int l = 0; l < 4; l++) begin
                w1[l*7 + 6 - k] = lane_out[l];
                w2[l*7 + 6 - k] = lane_out_m2[l];
            end
            ck[6 - k] = clk_lane_out;
        end
    endtask

    initial begin
        logic [27:0] w1, w2;
        logic [6:0]  ck;
        vec_t        extra;

        vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 1'b1, 1'b0, 1'b1,
                    {7'h20, 7'h65, 7'h3F, 7'h52}, {7'h46, 7'h05, 7'h73, 7'h4B}};
        vecs[1] = '{8'h03, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0,
                    {7'h00, 7'h02, 7'h00, 7'h60}, {7'h60, 7'h02, 7'h00, 7'h00}};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1,
                    {7'h7E, 7'h7F, 7'h7F, 7'h7F}, {7'h7E, 7'h7F, 7'h7F, 7'h7F}};
        vecs[3] = '{8'h80, 8'h01, 8'h40, 1'b0, 1'b0, 1'b1,
                    {7'h24, 7'h01, 7'h00, 7'h01}, {7'h10, 7'h11, 7'h00, 7'h02}};
        extra   = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 28'd0, 28'd0};

        rst_n = 1'b0; tx_en = 1'b0; pix_valid = 1'b0;
        pix_red = 8'd0; pix_green = 8'd0; pix_blue = 8'd0;
        pix_hsync = 1'b0; pix_vsync = 1'b0; pix_de = 1'b0;
        step();
        step();

        // Reset state
        check("rst lane_out", lane_out, 4'h0);
        check("rst clk_lane", clk_lane_out, 1'b0);
        check("rst fifo_level", fifo_level, 3'd0);
        check("rst pix_ready", pix_ready, 1'b0);
        check("rst underflow", underflow, 1'b0);
        check("rst ucnt", underflow_count, 16'd0);
        check("rst m2 ready", pix_ready_m2, 1'b0);
        check("rst m2 uflow", {underflow_m2, underflow_count_m2}, 17'd0);

        rst_n = 1'b1;
        #1;
        check("ready before edge", pix_ready, 1'b0);
        step();
        check("ready after edge", pix_ready, 1'b1);

        // Table: one pixel per run, both mappings and the clock pattern
        for (int i = 0; i < 4; i++) begin
            push(vecs[i]);
            check($sformatf("v%0d level after push", i), fifo_level, 3'd1);
            tx_en = 1'b1;
            step();
            check($sformatf("v%0d level after load", i), fifo_level, 3'd0);
            collect7(w1, w2, ck);
            for (int l = 0; l < 4; l++) begin
                check($sformatf("v%0d vesa L%0d", i, l), w1[l*7 +: 7], vecs[i].exp1[l*7 +: 7]);
                check($sformatf("v%0d jeida L%0d", i, l), w2[l*7 +: 7], vecs[i].exp2[l*7 +: 7]);
            end
            check($sformatf("v%0d clk pattern", i), ck, 7'b1100011);
            tx_en = 1'b0;
            step();
            check($sformatf("v%0d idle lanes", i), {lane_out, clk_lane_out}, 5'd0);
        end

        // Fill the FIFO while idle; a fifth pixel must be refused
        for (int i = 0; i < 4; i++) push(vecs[i]);
        check("full level", fifo_level, 3'd4);
        check("full ready", pix_ready, 1'b0);
        set_pix(extra);
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        check("full level hold", fifo_level, 3'd4);
        check("full m2 level", fifo_level_m2, 3'd4);
        tx_en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            collect7(w1, w2, ck);
            check($sformatf("drain%0d L0", i), w1[6:0], vecs[i].exp1[6:0]);
            check($sformatf("drain%0d L2", i), w1[20:14], vecs[i].exp1[20:14]);
        end
        collect7(w1, w2, ck);
        check("drain5 blank L0", w1[6:0], 7'h00);
        check("drain5 blank L2", w1[20:14], 7'h00);
        tx_en = 1'b0;
        step();

        // Underflow after an HS=1 pixel
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        check("uf clean", {underflow, underflow_count}, 17'd0);
        push(vecs[0]);
        tx_en = 1'b1;
        step();
        check("uf none yet", underflow, 1'b0);
        collect7(w1, w2, ck);
        check("uf pixel L2", w1[20:14], 7'h65);
        for (int i = 0; i < 2; i++) begin
            collect7(w1, w2, ck);
            check($sformatf("uf blank%0d L2", i), w1[20:14], 7'h04);
            check($sformatf("uf blank%0d L0", i), w1[6:0], 7'h00);
        end
        check("uf flag", underflow, 1'b1);
        check("uf count", underflow_count, EXP_UCNT3);
        collect7(w1, w2, ck);
        check("uf blank2 L2", w1[20:14], 7'h04);
        tx_en = 1'b0;
        step();

        // Reset in slot 3 with two entries queued
        for (int i = 0; i < 3; i++) push(vecs[2]);
        tx_en = 1'b1;
        step();
        check("mid level", fifo_level, 3'd2);
        step(); step(); step();
        check("mid lanes active", lane_out, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst lanes", {lane_out, clk_lane_out}, 5'd0);
        check("mid rst level", fifo_level, 3'd0);
        check("mid rst ready", pix_ready, 1'b0);
        check("mid rst uflow", {underflow, underflow_count}, 17'd0);
        rst_n = 1'b1;
        step();
        check("post rst blank flag", underflow, 1'b1);
        check("post rst ready", pix_ready, 1'b1);
        collect7(w1, w2, ck);
        check("post rst L0", w1[6:0], 7'h00);
        check("post rst L2", w1[20:14], 7'h00);
        check("post rst clk", ck, 7'b1100011);
        tx_en = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
